// File: rtl/ecc_secded_dec_pipe.sv
// ecc_secded_dec_pipe
// Two-stage pipelined SECDED (extended Hamming) decoder with saturating
// single/double error counters.
//
// Stage 1 computes the syndrome and the overall parity of the received word.
// Stage 2 classifies the error, corrects a single-bit error, and extracts the
// information bits into the output register.
//
// Handshake semantics (both sides): a transfer happens on a rising clock
// edge where valid and ready are both 1. A producer holds valid and its data
// stable until the transfer. ready_o may depend combinationally on ready_i.
//
// Ports
//   clk_i        single clock, all state on the rising edge
//   rst_i        synchronous active-high reset
//   valid_i      cw_i is valid
//   ready_o      block accepts cw_i this cycle
//   cw_i         received codeword (N+1 bits)
//   valid_o      result fields are valid
//   ready_i      downstream accepts the result
//   d_o          corrected information bits (K)
//   syndrome_o   computed syndrome (M)
//   sb_err_o     single-bit error detected and corrected
//   db_err_o     uncorrectable error detected
//   clr_cnt_i    synchronous clear of both counters
//   sb_cnt_o     saturating count of delivered single-bit errors
//   db_cnt_o     saturating count of delivered double-bit errors
module ecc_secded_dec_pipe #(
    parameter int K      = 32,
    parameter int P0_LSB = 1,
    parameter int CNT_W  = 16,
    // Smallest m with 2**m >= m+K+1.
    localparam int M = (K <= 4)   ? 3 :
                       (K <= 11)  ? 4 :
                       (K <= 26)  ? 5 :
                       (K <= 57)  ? 6 :
                       (K <= 120) ? 7 :
                       (K <= 247) ? 8 :
                       (K <= 502) ? 9 : 10,
    localparam int N = M + K
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [N:0]       cw_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [K-1:0]     d_o,
    output logic [M-1:0]     syndrome_o,
    output logic             sb_err_o,
    output logic             db_err_o,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] sb_cnt_o,
    output logic [CNT_W-1:0] db_cnt_o
);

    localparam logic [M-1:0]     N_L     = M'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Hamming position of information bit k: the k-th position in 1..N that
    // is not a power of two.
    function automatic int data_pos(input int k);
        int cnt;
        cnt = 0;
        for (int j = 1; j <= N; j++) begin
            if ((j & (j - 1)) != 0) begin
                if (cnt == k) return j;
                cnt++;
            end
        end
        return 0;
    endfunction

    // ------------------------------------------------------------------
    // Normalise the codeword so that bit j is Hamming position j and bit 0
    // is the extended parity p0, independent of P0_LSB.
    // ------------------------------------------------------------------
    logic [N:0]   hv_in;
    logic [M-1:0] syn_c;
    logic         par_c;

    always_comb begin
        hv_in = (P0_LSB != 0) ? cw_i : {cw_i[N-1:0], cw_i[N]};
    end

    // The syndrome is the XOR of the position numbers of all set bits; this
    // is the same as XOR-ing, for each syndrome bit i, every position with
    // bit i set.
    always_comb begin
        syn_c = '0;
        for (int j = 1; j <= N; j++) begin
            if (hv_in[j]) syn_c = syn_c ^ j[M-1:0];
        end
        par_c = ^hv_in;
    end

    // ------------------------------------------------------------------
    // Pipeline control
    // ------------------------------------------------------------------
    logic         s1_valid;
    logic [N:0]   s1_hv;
    logic [M-1:0] s1_syn;
    logic         s1_par;

    logic in_fire;
    logic out_fire;
    logic out_adv;

    always_comb begin
        out_adv  = s1_valid && (!valid_o || ready_i);
        ready_o  = !s1_valid || out_adv;
        in_fire  = valid_i && ready_o;
        out_fire = valid_o && ready_i;
    end

    // ------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_hv    <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_hv    <= hv_in;
            s1_syn   <= syn_c;
            s1_par   <= par_c;
        end else if (out_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: classify, correct, extract
    // ------------------------------------------------------------------
    logic         sb_c;
    logic         db_c;
    logic         flip_c;
    logic [N:0]   corr;
    logic [K-1:0] d_c;

    always_comb begin
        // Odd overall parity with a syndrome inside the codeword is a single
        // error (syndrome 0 means p0 itself flipped). Odd parity with a
        // syndrome beyond N, or even parity with a non-zero syndrome, cannot
        // be corrected.
        sb_c   = s1_par && (s1_syn <= N_L);
        db_c   = (s1_par && (s1_syn > N_L)) || (!s1_par && (s1_syn != '0));
        flip_c = sb_c && (s1_syn != '0);
        corr   = s1_hv;
        if (flip_c) corr[s1_syn] = ~s1_hv[s1_syn];
    end

    for (genvar g = 0; g < K; g++) begin : g_extract
        localparam int DP = data_pos(g);
        assign d_c[g] = corr[DP];
    end

    // Output register: fields only change when a new result is loaded, so
    // they stay stable while the result waits for ready_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o    <= 1'b0;
            d_o        <= '0;
            syndrome_o <= '0;
            sb_err_o   <= 1'b0;
            db_err_o   <= 1'b0;
        end else if (out_adv) begin
            valid_o    <= 1'b1;
            d_o        <= d_c;
            syndrome_o <= s1_syn;
            sb_err_o   <= sb_c;
            db_err_o   <= db_c;
        end else if (ready_i) begin
            valid_o    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Error counters: count delivered results only; clear beats increment.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            sb_cnt_o <= '0;
            db_cnt_o <= '0;
        end else if (out_fire) begin
            if (sb_err_o && (sb_cnt_o != CNT_MAX)) sb_cnt_o <= sb_cnt_o + 1'b1;
            if (db_err_o && (db_cnt_o != CNT_MAX)) db_cnt_o <= db_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_ecc_secded_dec_pipe.sv
// Testbench for ecc_secded_dec_pipe. Two instances share the stimulus:
// dut  : K=32, P0_LSB=1, CNT_W=16
// dut2 : K=32, P0_LSB=0, CNT_W=2 (same codeword, p0 moved to the MSB)
module tb_ecc_secded_dec_pipe;

    localparam int K = 32;
    localparam int M = 6;
    localparam int N = 38;
    localparam int W = K + M + 2;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic          valid_i;
    logic          ready_i;
    logic          clr_cnt_i;
    logic [N:0]    cw_i;
    logic [N:0]    cw2_i;

    logic          ready_o, valid_o, sb_err_o, db_err_o;
    logic [K-1:0]  d_o;
    logic [M-1:0]  syndrome_o;
    logic [15:0]   sb_cnt_o, db_cnt_o;

    logic          ready2_o, valid2_o, sb_err2_o, db_err2_o;
    logic [K-1:0]  d2_o;
    logic [M-1:0]  syndrome2_o;
    logic [1:0]    sb_cnt2_o, db_cnt2_o;

    assign cw2_i = {cw_i[0], cw_i[N:1]};

    ecc_secded_dec_pipe #(.K(K), .P0_LSB(1), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .cw_i(cw_i), .valid_o(valid_o), .ready_i(ready_i), .d_o(d_o),
        .syndrome_o(syndrome_o), .sb_err_o(sb_err_o), .db_err_o(db_err_o),
        .clr_cnt_i(clr_cnt_i), .sb_cnt_o(sb_cnt_o), .db_cnt_o(db_cnt_o)
    );

    ecc_secded_dec_pipe #(.K(K), .P0_LSB(0), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready2_o),
        .cw_i(cw2_i), .valid_o(valid2_o), .ready_i(ready_i), .d_o(d2_o),
        .syndrome_o(syndrome2_o), .sb_err_o(sb_err2_o), .db_err_o(db_err2_o),
        .clr_cnt_i(clr_cnt_i), .sb_cnt_o(sb_cnt2_o), .db_cnt_o(db_cnt2_o)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];   // {d, syndrome, sb, db}
    int sb_m = 0, db_m = 0, sb_m2 = 0, db_m2 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Encode: data in non-power-of-two positions ascending, each parity bit
    // makes its covered group even, p0 makes the whole word even.
    function automatic logic [N:0] encode(input logic [K-1:0] d);
        logic [N:0] v;
        logic       b;
        int         k;
        v = '0;
        k = 0;
        for (int j = 1; j <= N; j++) begin
            if ((j & (j - 1)) != 0) begin
                v[j] = d[k];
                k++;
            end
        end
        for (int i = 0; i < M; i++) begin
            b = 1'b0;
            for (int j = 1; j <= N; j++)
                if (((j >> i) & 1) == 1 && j != (1 << i)) b = b ^ v[j];
            v[1 << i] = b;
        end
        v[0] = ^v[N:1];
        return v;
    endfunction

    function automatic logic [K-1:0] extract(input logic [N:0] v);
        logic [K-1:0] d;
        int           k;
        d = '0;
        k = 0;
        for (int j = 1; j <= N; j++) begin
            if ((j & (j - 1)) != 0) begin
                d[k] = v[j];
                k++;
            end
        end
        return d;
    endfunction

    // Build a codeword with the listed positions (0 = p0, -1 = unused)
    // flipped, and the decoder response the rules require for it.
    task automatic make_word(input logic [K-1:0] d, input int f0, input int f1, input int f2,
                             output logic [N:0] cw, output logic [W-1:0] e);
        int           fl[3];
        int           f;
        int           cnt;
        logic [N:0]   v, c;
        logic [M-1:0] syn;
        logic         par, sb, db;
        fl[0] = f0; fl[1] = f1; fl[2] = f2;
        v   = encode(d);
        syn = '0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (fl[i] >= 0) begin
                f = fl[i];
                v[f] = ~v[f];
                syn = syn ^ f[M-1:0];
                cnt++;
            end
        end
        par = cnt[0];
        sb  = 1'b0;
        db  = 1'b0;
        c   = v;
        if (par && int'(syn) <= N) begin
            sb = 1'b1;
            if (syn != '0) c[syn] = ~c[syn];
        end else if (par || syn != '0) begin
            db = 1'b1;
        end
        cw = v;
        e  = {extract(c), syn, sb, db};
    endtask

    // ---------------- driver ----------------
    task automatic send(input logic [N:0] cw, input logic [W-1:0] e);
        int t;
        t       = 0;
        valid_i = 1'b1;
        cw_i    = cw;
        @(negedge clk);
        while (!ready_o && t < 100) begin
            @(posedge clk); #1;
            @(negedge clk);
            t++;
        end
        if (ready_o) exp_q.push_back(e);
        else begin
            checks++; failures++;
            $display("FAIL send_timeout actual=ready_o_low required=accept_within_100");
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [K-1:0] d, input int f0, input int f1, input int f2);
        logic [N:0]   cw;
        logic [W-1:0] e;
        make_word(d, f0, f1, f2, cw, e);
        send(cw, e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rst_i) begin
            exp_q.delete();
            sb_m = 0; db_m = 0; sb_m2 = 0; db_m2 = 0;
        end else begin
            check("sb_cnt",  64'(sb_cnt_o),  64'(sb_m));
            check("db_cnt",  64'(db_cnt_o),  64'(db_m));
            check("sb_cnt2", 64'(sb_cnt2_o), 64'(sb_m2));
            check("db_cnt2", 64'(db_cnt2_o), 64'(db_m2));
            if (valid_o || valid2_o) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output actual=valid required=idle at %0t", $time);
                end else begin
                    e = exp_q[0];
                    check("valid",    64'(valid_o),     64'd1);
                    check("d",        64'(d_o),         64'(e[W-1 -: K]));
                    check("syndrome", 64'(syndrome_o),  64'(e[M+1:2]));
                    check("sb_err",   64'(sb_err_o),    64'(e[1]));
                    check("db_err",   64'(db_err_o),    64'(e[0]));
                    check("valid2",   64'(valid2_o),    64'd1);
                    check("d2",       64'(d2_o),        64'(e[W-1 -: K]));
                    check("syndrome2",64'(syndrome2_o), 64'(e[M+1:2]));
                    check("sb_err2",  64'(sb_err2_o),   64'(e[1]));
                    check("db_err2",  64'(db_err2_o),   64'(e[0]));
                    if (ready_i) begin
                        void'(exp_q.pop_front());
                        if (e[1]) begin
                            if (sb_m < 65535) sb_m++;
                            if (sb_m2 < 3) sb_m2++;
                        end
                        if (e[0]) begin
                            if (db_m < 65535) db_m++;
                            if (db_m2 < 3) db_m2++;
                        end
                    end
                end
            end
            if (clr_cnt_i) begin
                sb_m = 0; db_m = 0; sb_m2 = 0; db_m2 = 0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    bit rnd_done;

    initial begin
        int t;
        int nf, f0, f1, f2;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; clr_cnt_i = 1'b0; cw_i = '0;
        rnd_done = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",    64'(valid_o),    64'd0);
        check("rst_d",        64'(d_o),        64'd0);
        check("rst_syndrome", 64'(syndrome_o), 64'd0);
        check("rst_flags",    64'({sb_err_o, db_err_o}), 64'd0);
        check("rst_cnts",     64'({sb_cnt_o, db_cnt_o}), 64'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(ready_o), 64'd1);
        @(posedge clk); #1;

        // Clean 0xDEADBEEF, latency 2
        send_word(32'hDEADBEEF, -1, -1, -1);
        @(negedge clk);
        check("latency_early", 64'(valid_o), 64'd0);
        @(negedge clk);
        check("latency_valid", 64'(valid_o),    64'd1);
        check("clean_d",       64'(d_o),        64'hDEADBEEF);
        check("clean_d_p0msb", 64'(d2_o),       64'hDEADBEEF);
        check("clean_syn",     64'(syndrome_o), 64'd0);
        check("clean_flags",   64'({sb_err_o, db_err_o}), 64'd0);
        drain();

        // Position 5 flipped
        send_word(32'hDEADBEEF, 5, -1, -1);
        repeat (2) @(negedge clk);
        check("sb5_d",   64'(d_o),        64'hDEADBEEF);
        check("sb5_syn", 64'(syndrome_o), 64'd5);
        check("sb5_sb",  64'(sb_err_o),   64'd1);
        @(negedge clk);
        check("sb5_cnt", 64'(sb_cnt_o),   64'd1);
        drain();

        // p0 only flipped
        send_word(32'hDEADBEEF, 0, -1, -1);
        repeat (2) @(negedge clk);
        check("p0_d",   64'(d_o),        64'hDEADBEEF);
        check("p0_syn", 64'(syndrome_o), 64'd0);
        check("p0_sb",  64'(sb_err_o),   64'd1);
        drain();

        // Positions 3 and 6 flipped: uncorrected data has d0 and d2 inverted
        send_word(32'hDEADBEEF, 3, 6, -1);
        repeat (2) @(negedge clk);
        check("db_d",   64'(d_o),        64'hDEADBEEA);
        check("db_syn", 64'(syndrome_o), 64'd5);
        check("db_flags", 64'({sb_err_o, db_err_o}), 64'b01);
        @(negedge clk);
        check("db_cnt", 64'(db_cnt_o), 64'd1);
        drain();

        // Backpressure: three back-to-back words with ready_i low
        ready_i = 1'b0;
        send_word($urandom, -1, -1, -1);
        send_word($urandom, 7, -1, -1);
        @(negedge clk);
        check("bp_ready_low", 64'(ready_o), 64'd0);
        @(posedge clk); #1;
        fork
            send_word($urandom, 9, 20, -1);
            begin
                repeat (3) @(posedge clk);
                #1 ready_i = 1'b1;
            end
        join
        drain();

        // Saturation of the 2-bit counters
        for (int i = 0; i < 5; i++) send_word($urandom, $urandom_range(0, N), -1, -1);
        drain();
        @(negedge clk);
        check("sat_cnt2", 64'(sb_cnt2_o), 64'd3);
        @(posedge clk); #1;

        // Clear coinciding with an increment
        ready_i = 1'b0;
        send_word($urandom, 11, -1, -1);
        t = 0;
        @(negedge clk);
        while (!valid_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        ready_i = 1'b1; clr_cnt_i = 1'b1;
        @(posedge clk); #1;
        clr_cnt_i = 1'b0;
        @(negedge clk);
        check("clr_wins",  64'(sb_cnt_o),  64'd0);
        check("clr_wins2", 64'(sb_cnt2_o), 64'd0);
        @(posedge clk); #1;

        // Reset with two words in flight
        send_word($urandom, 13, -1, -1);
        drain();
        ready_i = 1'b0;
        send_word($urandom, 1, -1, -1);
        send_word($urandom, 2, 30, -1);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0; ready_i = 1'b1;
        @(negedge clk);
        check("flush_valid", 64'(valid_o),  64'd0);
        check("flush_ready", 64'(ready_o),  64'd1);
        check("flush_cnts",  64'({sb_cnt_o, db_cnt_o}), 64'd0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    nf = $urandom_range(0, 3);
                    f0 = $urandom_range(0, N);
                    do f1 = $urandom_range(0, N); while (f1 == f0);
                    do f2 = $urandom_range(0, N); while (f2 == f0 || f2 == f1);
                    send_word($urandom, (nf > 0) ? f0 : -1, (nf > 1) ? f1 : -1, (nf > 2) ? f2 : -1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
